regfile_wb_sched: RTL and testbench

REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

---
 rtl/regfile_wb_sched_pkg.sv | 11 +
 rtl/regfile_wb_sched_wb_fwd_mux.sv | 37 +++
 rtl/regfile_wb_sched.sv | 113 +++++++++++
 tb/tb_regfile_wb_sched.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// rtl/regfile_wb_sched_pkg.sv - shared constants and state encoding for the write-back scheduler
package regfile_wb_sched_pkg;
  localparam int DATA_W = 64;
  localparam logic [3:0] REG_NONE = 4'hf;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WR1  = 2'd1,
    WB_WR2  = 2'd2
  } wb_state_e;
endpackage

// File: rtl/regfile_wb_sched_wb_fwd_mux.sv
// rtl/regfile_wb_sched_wb_fwd_mux.sv - operand select: pending M data, then current write, then raw read
// Forwarding is built only when WB_FWD_EN is defined; otherwise raw read data passes through.
module wb_fwd_mux
  import regfile_wb_sched_pkg::*;
(
  input  logic [3:0]        src,
  input  logic [DATA_W-1:0] rd,
  input  logic              pend_en,
  input  logic [3:0]        pend_addr,
  input  logic [DATA_W-1:0] pend_data,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] val
);

`ifdef WB_FWD_EN
  always_comb begin
    val = '0;
    if (src != REG_NONE) begin
      // The pending M write lands after the current one, so it is the youngest value.
      if (pend_en && (pend_addr == src)) val = pend_data;
      else if (wr_en && (wr_addr == src)) val = wr_data;
      else val = rd;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{pend_en, pend_addr, pend_data, wr_en, wr_addr, wr_data};

  always_comb begin
    val = '0;
    if (src != REG_NONE) val = rd;
  end
`endif

endmodule

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - serialises E/M write-backs onto one register-file write port
// Optional operand forwarding is enabled with macro WB_FWD_EN.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [3:0]        dste_i,
  input  logic [3:0]        dstm_i,
  input  logic [DATA_W-1:0] vale_i,
  input  logic [DATA_W-1:0] valm_i,
  output logic              wr_en_o,
  output logic [3:0]        wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic [3:0]        srca_i,
  input  logic [3:0]        srcb_i,
  input  logic [DATA_W-1:0] rda_i,
  input  logic [DATA_W-1:0] rdb_i,
  output logic [DATA_W-1:0] vala_o,
  output logic [DATA_W-1:0] valb_o
);

  wb_state_e         state_q, state_d;
  logic [3:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              pend_q, pend_d;
  logic [3:0]        pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              accept, has_e, has_m;

  assign wb_ready_o = !((state_q == WB_WR1) && pend_q);
  assign accept     = wb_valid_i && wb_ready_o && rst_n_i;
  assign has_e      = (dste_i != REG_NONE);
  assign has_m      = (dstm_i != REG_NONE);

  assign wr_en_o   = (state_q != WB_IDLE);
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

  always_comb begin
    state_d     = WB_IDLE;
    wr_addr_d   = REG_NONE;
    wr_data_d   = '0;
    pend_d      = 1'b0;
    pend_addr_d = REG_NONE;
    pend_data_d = '0;
    if (accept && (has_e || has_m)) begin
      state_d = WB_WR1;
      if (has_e) begin
        wr_addr_d = dste_i;
        wr_data_d = vale_i;
        // Same-register E/M pairs still issue both; M goes last so it wins.
        if (has_m) begin
          pend_d      = 1'b1;
          pend_addr_d = dstm_i;
          pend_data_d = valm_i;
        end
      end else begin
        wr_addr_d = dstm_i;
        wr_data_d = valm_i;
      end
    end else if ((state_q == WB_WR1) && pend_q) begin
      state_d   = WB_WR2;
      wr_addr_d = pend_addr_q;
      wr_data_d = pend_data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= WB_IDLE;
      wr_addr_q   <= REG_NONE;
      wr_data_q   <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= REG_NONE;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  wb_fwd_mux u_fwd_a (
    .src       (srca_i),
    .rd        (rda_i),
    .pend_en   (pend_q),
    .pend_addr (pend_addr_q),
    .pend_data (pend_data_q),
    .wr_en     (wr_en_o),
    .wr_addr   (wr_addr_q),
    .wr_data   (wr_data_q),
    .val       (vala_o)
  );

  wb_fwd_mux u_fwd_b (
    .src       (srcb_i),
    .rd        (rdb_i),
    .pend_en   (pend_q),
    .pend_addr (pend_addr_q),
    .pend_data (pend_data_q),
    .wr_en     (wr_en_o),
    .wr_addr   (wr_addr_q),
    .wr_data   (wr_data_q),
    .val       (valb_o)
  );

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - scoreboard bench: expected writes queued at acceptance, monitor compares each cycle
module tb_regfile_wb_sched;

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [3:0]  dste = 4'hf, dstm = 4'hf;
  logic [63:0] vale = '0, valm = '0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  srca = 4'hf, srcb = 4'hf;
  logic [63:0] rda = '0, rdb = '0;
  logic [63:0] vala, valb;

  wr_t  exp_q[$];
  logic model_ready = 1'b1;
  logic chk_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  regfile_wb_sched dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .wb_valid_i (wb_valid),
    .wb_ready_o (wb_ready),
    .dste_i     (dste),
    .dstm_i     (dstm),
    .vale_i     (vale),
    .valm_i     (valm),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .srca_i     (srca),
    .srcb_i     (srcb),
    .rda_i      (rda),
    .rdb_i      (rdb),
    .vala_o     (vala),
    .valb_o     (valb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  // Reference operand value: newest scheduled write to that register wins.
  function automatic logic [63:0] ref_operand(input logic [3:0] src, input logic [63:0] rd);
    logic [63:0] v;
    if (src == 4'hf) return 64'd0;
    v = rd;
`ifdef WB_FWD_EN
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].addr == src) v = exp_q[i].data;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {63'd0, wb_ready}, {63'd0, model_ready});
      check("vala", vala, ref_operand(srca, rda));
      check("valb", valb, ref_operand(srcb, rdb));
      if (exp_q.size() > 0) begin
        check("wr_en", {63'd0, wr_en}, 64'd1);
        check("wr_addr", {60'd0, wr_addr}, {60'd0, exp_q[0].addr});
        check("wr_data", wr_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        check("wr_en_idle", {63'd0, wr_en}, 64'd0);
        check("wr_addr_idle", {60'd0, wr_addr}, 64'hf);
        check("wr_data_idle", wr_data, 64'd0);
      end
    end
  end

  task automatic step(input logic v, input logic [3:0] de, input logic [3:0] dm,
                      input logic [63:0] ve, input logic [63:0] vm,
                      input logic [3:0] sa, input logic [3:0] sb,
                      input logic [63:0] ra, input logic [63:0] rb, input logic rst);
    wr_t w;
    wb_valid = v; dste = de; dstm = dm; vale = ve; valm = vm;
    srca = sa; srcb = sb; rda = ra; rdb = rb; rst_n = rst;
    @(posedge clk);
    #1;
    if (!rst) begin
      exp_q.delete();
      model_ready = 1'b1;
    end else if (v && model_ready) begin
      if (de != 4'hf) begin w.addr = de; w.data = ve; exp_q.push_back(w); end
      if (dm != 4'hf) begin w.addr = dm; w.data = vm; exp_q.push_back(w); end
      model_ready = !((de != 4'hf) && (dm != 4'hf));
    end else begin
      model_ready = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'hf, 4'hf, 0, 0, 4'hf, 4'hf, 0, 0, 1);
  endtask

  initial begin
    step(0, 4'hf, 4'hf, 0, 0, 4'hf, 4'hf, 0, 0, 0);
    step(0, 4'hf, 4'hf, 0, 0, 4'hf, 4'hf, 0, 0, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);
    // single E write
    step(1, 4'd3, 4'hf, 64'h55, 64'h0, 4'hf, 4'hf, 0, 0, 1);
    idle(2);
    // dual write to the same register, forwarding probe on srca=4 during WR1
    step(1, 4'd4, 4'd4, 64'h1F8, 64'h77, 4'hf, 4'hf, 0, 0, 1);
    step(1, 4'd9, 4'hf, 64'hdead, 64'h0, 4'd4, 4'd4, 64'h0, 64'h0, 1);
    idle(2);
    // back-to-back singles
    step(1, 4'd1, 4'hf, 64'h11, 64'h0, 4'd1, 4'hf, 64'h5, 0, 1);
    step(1, 4'd2, 4'hf, 64'h22, 64'h0, 4'd1, 4'd2, 64'h5, 64'h6, 1);
    step(1, 4'd3, 4'hf, 64'h33, 64'h0, 4'd2, 4'd3, 64'h7, 64'h8, 1);
    idle(2);
    // reset during WR1 of a dual write drops the M write
    step(1, 4'd5, 4'd6, 64'haa, 64'hbb, 4'hf, 4'hf, 0, 0, 1);
    step(0, 4'hf, 4'hf, 0, 0, 4'd6, 4'hf, 64'h1, 0, 0);
    idle(2);
    // no-destination request, and an M-only request
    step(1, 4'hf, 4'hf, 64'h1, 64'h2, 4'hf, 4'hf, 0, 0, 1);
    idle(1);
    step(1, 4'hf, 4'd7, 64'h1, 64'h99, 4'hf, 4'hf, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 600; i++) begin
      logic [3:0] de, dm;
      de = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom_range(0, 14));
      dm = ($urandom_range(0, 2) == 0) ? 4'hf : 4'($urandom_range(0, 14));
      step($urandom_range(0, 3) != 0, de, dm, {$urandom, $urandom}, {$urandom, $urandom},
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 40) != 0);
    end
    idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
